// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // FSM encoding kept as plain constants so legacy code can compare raw bits
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  typedef logic [1:0] arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side (fetch/data) and external-bus signals of the memory arbiter.
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_addr_ok;
  logic          i_data_ok;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_wr;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_addr_ok;
  logic          d_data_ok;
  logic [DW-1:0] d_rdata;

  logic          bus_req;
  logic          bus_wr;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok;
  logic          bus_data_ok;
  logic [DW-1:0] bus_rdata;

  // Arbiter side
  modport master (
    input  i_req, i_addr,
    output i_addr_ok, i_data_ok, i_rdata,
    input  d_req, d_wr, d_size, d_addr, d_wdata,
    output d_addr_ok, d_data_ok, d_rdata,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  // Requesters plus external slave
  modport slave (
    output i_req, i_addr,
    input  i_addr_ok, i_data_ok, i_rdata,
    output d_req, d_wr, d_size, d_addr, d_wdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between fetch and data ports: one outstanding
// transaction, data priority, fetch guaranteed a slot after MAX_D_BURST data grants.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_D_BURST = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.master bus
);

  localparam int CW = (MAX_D_BURST < 1) ? 1 : $clog2(MAX_D_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_D_BURST);

  typedef struct packed {
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_req_t;

  arb_state_t    r_state;
  arb_owner_t    r_owner;
  logic [CW-1:0] r_burst;
  bus_req_t      r_req;

  logic w_grant_i;
  logic w_grant_d;
  logic w_addr_acc;
  logic w_data_done;
  logic w_own_i;
  logic w_own_d;
  logic w_i_data_ok;
  logic w_d_data_ok;

  assign w_grant_i   = bus.i_req & (~bus.d_req | (r_burst == BURST_MAX));
  assign w_grant_d   = bus.d_req & ~w_grant_i;
  assign w_addr_acc  = (r_state == ST_ADDR) & bus.bus_addr_ok;
  // Completion either in DATA or folded into the address-accept cycle
  assign w_data_done = ((r_state == ST_DATA) | w_addr_acc) & bus.bus_data_ok;
  assign w_own_i     = (r_owner == OWN_I);
  assign w_own_d     = (r_owner == OWN_D);

  // Arbitration FSM, owner, starvation counter and latched request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_NONE;
      r_burst <= '0;
      r_req   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_i) begin
            r_state     <= ST_ADDR;
            r_owner     <= OWN_I;
            r_burst     <= '0;
            r_req.wr    <= 1'b0;
            r_req.size  <= SZ_WORD;
            r_req.addr  <= bus.i_addr;
            r_req.wdata <= '0;
          end else if (w_grant_d) begin
            r_state     <= ST_ADDR;
            r_owner     <= OWN_D;
            if (!bus.i_req) begin
              r_burst <= '0;
            end else if (r_burst != BURST_MAX) begin
              r_burst <= r_burst + CW'(1);
            end else begin
              r_burst <= r_burst;
            end
            r_req.wr    <= bus.d_wr;
            r_req.size  <= bus.d_size;
            r_req.addr  <= bus.d_addr;
            r_req.wdata <= bus.d_wdata;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (w_data_done) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_NONE;
          end else if (w_addr_acc) begin
            r_state <= ST_DATA;
          end else begin
            r_state <= ST_ADDR;
          end
        end
        ST_DATA: begin
          if (bus.bus_data_ok) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_NONE;
          end else begin
            r_state <= ST_DATA;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_owner <= OWN_NONE;
        end
      endcase
    end
  end

  assign w_i_data_ok = w_data_done & w_own_i;
  assign w_d_data_ok = w_data_done & w_own_d;

  assign bus.i_addr_ok = w_addr_acc & w_own_i;
  assign bus.i_data_ok = w_i_data_ok;
  assign bus.i_rdata   = w_i_data_ok ? bus.bus_rdata : '0;
  assign bus.d_addr_ok = w_addr_acc & w_own_d;
  assign bus.d_data_ok = w_d_data_ok;
  assign bus.d_rdata   = w_d_data_ok ? bus.bus_rdata : '0;

  // Bus fields come only from the latched request so they cannot glitch with requester inputs
  assign bus.bus_req   = (r_state == ST_ADDR);
  assign bus.bus_wr    = r_req.wr;
  assign bus.bus_size  = r_req.size;
  assign bus.bus_addr  = r_req.addr;
  assign bus.bus_wdata = r_req.wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed plus randomized bench for mem_bus_arbiter; grant order and bus fields
// are predicted from the arbitration rules by a small model.
module tb_mem_bus_arbiter;

  localparam int MAXB = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   m_burst;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_bus_arbiter #(.AW(32), .DW(32), .MAX_D_BURST(MAXB)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.master)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected acks/rdata for both ports given the owner and which pulses should be live
  task automatic chk_acks(input string tag, input int own, input logic a, input logic d, input logic [31:0] rd);
    chk1({tag, "_i_aok"}, bus.i_addr_ok, (own == 1) && a);
    chk1({tag, "_i_dok"}, bus.i_data_ok, (own == 1) && d);
    chk32({tag, "_i_rd"}, bus.i_rdata, ((own == 1) && d) ? rd : 32'h0);
    chk1({tag, "_d_aok"}, bus.d_addr_ok, (own == 2) && a);
    chk1({tag, "_d_dok"}, bus.d_data_ok, (own == 2) && d);
    chk32({tag, "_d_rd"}, bus.d_rdata, ((own == 2) && d) ? rd : 32'h0);
  endtask

  // Reference arbitration: who wins in IDLE, and how the fairness count evolves
  function automatic int pick_owner();
    if (bus.i_req && (!bus.d_req || m_burst == MAXB)) return 1;
    else if (bus.d_req) return 2;
    else return 0;
  endfunction

  task automatic model_grant(input int own);
    if (own == 1 || !bus.i_req) m_burst = 0;
    else if (m_burst < MAXB) m_burst = m_burst + 1;
  endtask

  task automatic chk_bus(input string tag, input int own, input logic [31:0] ea, input logic ew,
                         input logic [1:0] es, input logic [31:0] ewd);
    chk1({tag, "_req"}, bus.bus_req, 1'b1);
    chk32({tag, "_addr"}, bus.bus_addr, ea);
    chk1({tag, "_wr"}, bus.bus_wr, ew);
    chk32({tag, "_size"}, 32'(bus.bus_size), 32'(es));
    if (own == 2) chk32({tag, "_wdata"}, bus.bus_wdata, ewd);
  endtask

  // One transaction: requests already set in an IDLE cycle; ends at the next IDLE cycle
  task automatic run_txn(input int al, input bit comb, input int dl, input bit keep,
                         input bit scramble, input logic [31:0] rd);
    int own;
    logic [31:0] ea, ewd;
    logic ew;
    logic [1:0] es;
    own = pick_owner();
    model_grant(own);
    if (own == 1) begin
      ea = bus.i_addr; ew = 1'b0; es = 2'd2; ewd = 32'h0;
    end else begin
      ea = bus.d_addr; ew = bus.d_wr; es = bus.d_size; ewd = bus.d_wdata;
    end
    @(negedge clk);
    for (int k = 0; k < al; k++) begin
      bus.bus_rdata = $urandom;
      if (scramble) bus.d_addr = $urandom;
      #1;
      chk_bus("addr_wait", own, ea, ew, es, ewd);
      chk_acks("addr_wait", own, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
    end
    bus.bus_addr_ok = 1'b1;
    bus.bus_data_ok = comb;
    bus.bus_rdata   = rd;
    #1;
    chk_bus("addr_acc", own, ea, ew, es, ewd);
    chk_acks("addr_acc", own, 1'b1, comb, rd);
    @(negedge clk);
    bus.bus_addr_ok = 1'b0;
    bus.bus_data_ok = 1'b0;
    if (!keep) begin
      if (own == 1) bus.i_req = 1'b0;
      else bus.d_req = 1'b0;
    end
    if (!comb) begin
      for (int k = 0; k < dl; k++) begin
        bus.bus_rdata = $urandom;
        #1;
        chk1("data_wait_req", bus.bus_req, 1'b0);
        chk_acks("data_wait", own, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
      end
      bus.bus_data_ok = 1'b1;
      bus.bus_rdata   = rd;
      #1;
      chk1("data_done_req", bus.bus_req, 1'b0);
      chk_acks("data_done", own, 1'b0, 1'b1, rd);
      @(negedge clk);
      bus.bus_data_ok = 1'b0;
    end
    #1;
    chk1("idle_gap_req", bus.bus_req, 1'b0);
    chk_acks("idle_gap", own, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n           = 1'b0;
    bus.i_req       = 1'b0;
    bus.i_addr      = 32'h0;
    bus.d_req       = 1'b0;
    bus.d_wr        = 1'b0;
    bus.d_size      = 2'd0;
    bus.d_addr      = 32'h0;
    bus.d_wdata     = 32'h0;
    bus.bus_addr_ok = 1'b0;
    bus.bus_data_ok = 1'b0;
    bus.bus_rdata   = 32'h0;
    m_burst         = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_bus_req", bus.bus_req, 1'b0);
    chk32("rst_bus_addr", bus.bus_addr, 32'h0);
    chk1("rst_bus_wr", bus.bus_wr, 1'b0);
    chk_acks("rst", 0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch only: addr_ok on cycle 2, data_ok on cycle 4
    bus.i_req  = 1'b1;
    bus.i_addr = 32'hBFC0_0000;
    run_txn(1, 1'b0, 1, 1'b0, 1'b0, 32'h3C1D_0000);

    // Simultaneous requests: data write first, fetch after an IDLE gap
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'hBFC0_0004;
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b1;
    bus.d_size  = 2'd0;
    bus.d_addr  = 32'h8000_1000;
    bus.d_wdata = 32'hDEAD_BEEF;
    run_txn(0, 1'b0, 1, 1'b0, 1'b0, 32'h1111_2222);
    run_txn(0, 1'b0, 0, 1'b0, 1'b0, 32'h3333_4444);

    // Starvation guard: both held, expect D, D, I, D, D, I
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'hBFC0_0100;
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b0;
    bus.d_size  = 2'd1;
    bus.d_addr  = 32'h8000_2000;
    for (int n = 0; n < 6; n++) run_txn(0, 1'b0, 0, 1'b1, 1'b0, 32'h5000_0000 + 32'(n));
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);

    // Combined address/data acknowledge skips DATA
    bus.d_req  = 1'b1;
    bus.d_wr   = 1'b0;
    bus.d_size = 2'd2;
    bus.d_addr = 32'h8000_3000;
    run_txn(0, 1'b1, 0, 1'b0, 1'b0, 32'hCAFE_F00D);

    // Slave withholds addr_ok for 10 cycles while d_addr wanders
    bus.d_req  = 1'b1;
    bus.d_wr   = 1'b1;
    bus.d_size = 2'd2;
    bus.d_addr = 32'h8000_4000;
    bus.d_wdata = 32'h0BAD_F00D;
    run_txn(10, 1'b0, 2, 1'b0, 1'b1, 32'h0);

    // Asynchronous reset while in DATA
    bus.i_req  = 1'b1;
    bus.i_addr = 32'hBFC0_0200;
    @(negedge clk);
    bus.bus_addr_ok = 1'b1;
    @(negedge clk);
    bus.bus_addr_ok = 1'b0;
    bus.i_req       = 1'b0;
    bus.bus_data_ok = 1'b1;
    bus.bus_rdata   = 32'h7777_7777;
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_bus_req", bus.bus_req, 1'b0);
    chk32("arst_bus_addr", bus.bus_addr, 32'h0);
    chk_acks("arst", 0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    bus.bus_data_ok = 1'b0;
    rst_n   = 1'b1;
    m_burst = 0;
    @(negedge clk);
    #1;
    chk1("arst_idle_req", bus.bus_req, 1'b0);
    bus.i_req  = 1'b1;
    bus.i_addr = 32'hBFC0_0300;
    run_txn(1, 1'b0, 1, 1'b0, 1'b0, 32'h2468_ACE0);

    // Randomized traffic; losers keep their request pending across transactions
    for (int it = 0; it < 60; it++) begin
      if (!bus.i_req && $urandom_range(0, 1) == 1) begin
        bus.i_req  = 1'b1;
        bus.i_addr = $urandom;
      end
      if (!bus.d_req && $urandom_range(0, 2) != 0) begin
        bus.d_req   = 1'b1;
        bus.d_wr    = 1'($urandom_range(0, 1));
        bus.d_size  = 2'($urandom_range(0, 2));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end
      if (!bus.i_req && !bus.d_req) begin
        bus.i_req  = 1'b1;
        bus.i_addr = $urandom;
      end
      run_txn($urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
              1'b0, 1'b0, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus (req/addr_ok/data_ok handshake) between the fetch stage (instruction port) and the memory stage (data port).
- Sits between the datapath's pc/instr and mread/mwrite/rd paths and the single external bus.
- One outstanding transaction at a time; data has priority, with a starvation guard for fetch.
- Requesters derive their stall signals from the addr_ok/data_ok pulses.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_D_BURST, 2, consecutive data grants allowed while fetch is waiting

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request
- i_addr  in  AW  fetch address
- i_addr_ok  out  1  fetch address accepted (1-cycle pulse)
- i_data_ok  out  1  fetch data valid (1-cycle pulse)
- i_rdata  out  DW  fetch read data
- d_req  in  1  data request
- d_wr  in  1  1=write, 0=read
- d_size  in  2  0=byte, 1=half, 2=word
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_addr_ok  out  1  data address accepted (pulse)
- d_data_ok  out  1  data complete (pulse)
- d_rdata  out  DW  data read data
- bus_req  out  1  bus request
- bus_wr  out  1  bus write
- bus_size  out  2  bus size
- bus_addr  out  AW  bus address
- bus_wdata  out  DW  bus write data
- bus_addr_ok  in  1  slave accepted address
- bus_data_ok  in  1  slave completed
- bus_rdata  in  DW  slave read data

Behaviour:
- Reset: reset low clears state to IDLE, owner=NONE, burst counter=0 and all outputs to 0, regardless of clock. Reset mid-transaction abandons it; the slave is reset on the same net.
- FSM states: IDLE, ADDR, DATA. Owner register is NONE, I or D.
- IDLE, requester selection:
  - d_req wins, unless i_req=1 and the burst counter equals MAX_D_BURST; then I wins.
  - The winner's fields are latched into request registers. Fetch latches wr=0, size=2.
  - Go to ADDR. With no request, stay in IDLE.
- ADDR:
  - bus_req=1; bus_wr/size/addr/wdata driven from the latched registers only, never combinationally from requester inputs.
  - On bus_addr_ok: pulse the owner's x_addr_ok in the same cycle and go to DATA.
  - If bus_addr_ok and bus_data_ok are both high in the same cycle: pulse both owner acks and go to IDLE.
- DATA:
  - bus_req=0. On bus_data_ok: pulse the owner's x_data_ok, then go to IDLE.
  - x_rdata = bus_rdata combinationally, valid only while x_data_ok=1. Otherwise x_rdata is held at 0.
- Burst counter:
  - Increments on each D grant while i_req=1, saturating at MAX_D_BURST.
  - Clears on any I grant, or when i_req=0 at a grant.
- Minimum transaction latency: 1 cycle IDLE to ADDR, then slave-dependent. Back-to-back transactions need one IDLE cycle between them.
- Requester contract: hold x_req and its fields stable until x_addr_ok. A requester may drop x_req before a grant; the arbiter only samples in IDLE.
- The non-owner's acks stay 0 throughout.
- Write transactions still wait for bus_data_ok before d_data_ok.

Decomposition:
- Shared package `mips.svh` holds:
  - enum `arb_owner_t` {NONE, I, D}
  - enum `arb_state_t` {IDLE, ADDR, DATA}
  - typedef `bus_req_t` struct {wr, size, addr, wdata}
  - size constants `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`
- Single module. A sub-module is not warranted; the latched request register is a `bus_req_t` flop inside the block.

Test Plan:
- Fetch only: i_req=1, i_addr=0xBFC00000; slave gives addr_ok at cycle 2 and data_ok with rdata=0x3C1D0000 at cycle 4 -> bus_addr=0xBFC00000, bus_wr=0, bus_size=2; i_addr_ok pulses at cycle 2; i_data_ok pulses at cycle 4 with i_rdata=0x3C1D0000; d_* acks stay 0.
- Both requesting in the same IDLE cycle, d_req write (d_addr=0x80001000, d_wdata=0xDEADBEEF, size=0) -> data granted first with bus_wr=1, bus_size=0; fetch is granted only after d_data_ok plus one IDLE cycle.
- Starvation guard: d_req and i_req held high continuously, MAX_D_BURST=2 -> grant sequence D, D, I, D, D, I.
- Combined ack: slave asserts bus_addr_ok and bus_data_ok in the same cycle -> d_addr_ok and d_data_ok pulse together; FSM returns to IDLE next cycle; DATA is skipped.
- Reset in DATA: drive reset low asynchronously mid-cycle -> bus_req and all acks are 0 immediately; state is IDLE after release; a new i_req is granted normally.
- Slave withholds bus_addr_ok for 10 cycles -> bus_req and bus_addr stay stable throughout, even if d_addr changes.
